// File: rtl/contrast_transform_arbiter.sv
// Round-robin sequencer sharing one req-ack ContrastTransform datapath among several
// requesters; results come back tagged with the requester id, and stalled jobs are aborted.
module contrast_transform_arbiter #(
    parameter int requesters     = 4,
    parameter int id_width       = 2,
    parameter int color_channels = 3,
    parameter int color_width    = 8,
    parameter int timeout        = 255
) (
    input  logic                                              clk,
    input  logic                                              rst,
    input  logic [requesters-1:0]                             req_valid,
    input  logic [requesters*24-1:0]                          req_scale,
    input  logic [requesters*color_channels*color_width-1:0]  req_data,
    output logic [requesters-1:0]                             req_ready,
    output logic                                              rsp_valid,
    output logic [id_width-1:0]                               rsp_id,
    output logic [color_channels*color_width-1:0]             rsp_data,
    output logic                                              rsp_error,
    output logic [23:0]                                       ct_scale,
    output logic                                              ct_in_enable,
    output logic [color_channels*color_width-1:0]             ct_in_data,
    input  logic                                              ct_out_ready,
    input  logic [color_channels*color_width-1:0]             ct_out_data,
    output logic                                              busy
);

    localparam int CW = color_channels * color_width;
    localparam logic [15:0] TIMEOUT_CNT = 16'(timeout);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    state_t              state, state_nx;
    logic [id_width-1:0] last_q;
    logic [id_width-1:0] win_id;
    logic                win_found;
    logic [23:0]         win_scale;
    logic [CW-1:0]       win_data;
    logic [15:0]         wait_cnt;
    logic                job_done;

    // Two passes give the round-robin order: ids above last first, then 0..last.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        win_scale = '0;
        win_data  = '0;
        for (int i = 0; i < requesters; i++) begin
            if (!win_found && req_valid[i] && (i > int'(last_q))) begin
                win_found = 1'b1;
                win_id    = id_width'(i);
                win_scale = req_scale[i*24 +: 24];
                win_data  = req_data[i*CW +: CW];
            end
        end
        for (int i = 0; i < requesters; i++) begin
            if (!win_found && req_valid[i] && (i <= int'(last_q))) begin
                win_found = 1'b1;
                win_id    = id_width'(i);
                win_scale = req_scale[i*24 +: 24];
                win_data  = req_data[i*CW +: CW];
            end
        end
    end

    // Handshake: a request transfers on a clock edge where req_valid[i] & req_ready[i];
    // req_ready is one-hot on the winner, only in IDLE and never while rst is high.
    always_comb begin
        req_ready = '0;
        if (state == ST_IDLE && !rst && win_found) begin
            req_ready[win_id] = 1'b1;
        end
    end

    assign job_done = ct_out_ready || (wait_cnt == TIMEOUT_CNT);

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:    if (win_found) state_nx = ST_WAIT;
            ST_WAIT:    if (job_done) state_nx = ST_RELEASE;
            ST_RELEASE: state_nx = ST_IDLE;
            default:    state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            last_q     <= id_width'(requesters - 1);
            rsp_id     <= '0;
            ct_scale   <= '0;
            ct_in_data <= '0;
            rsp_data   <= '0;
            rsp_error  <= 1'b0;
            wait_cnt   <= '0;
        end else begin
            state <= state_nx;
            case (state)
                ST_IDLE: begin
                    if (win_found) begin
                        last_q     <= win_id;
                        rsp_id     <= win_id;
                        ct_scale   <= win_scale;
                        ct_in_data <= win_data;
                        wait_cnt   <= '0;
                    end
                end
                ST_WAIT: begin
                    // A result on the last allowed cycle wins over the abort.
                    if (ct_out_ready) begin
                        rsp_data  <= ct_out_data;
                        rsp_error <= 1'b0;
                    end else if (wait_cnt == TIMEOUT_CNT) begin
                        rsp_data  <= '0;
                        rsp_error <= 1'b1;
                    end else if (wait_cnt != 16'hffff) begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign ct_in_enable = (state == ST_WAIT);
    assign rsp_valid    = (state == ST_RELEASE);
    assign busy         = (state != ST_IDLE);

endmodule

// File: tb/tb_contrast_transform_arbiter.sv
// Directed-plus-random bench for contrast_transform_arbiter; a job-level model predicts
// grant order, latched scale/data, response timing, data and timeout aborts.
module tb_contrast_transform_arbiter;

    localparam int N   = 4;
    localparam int IDW = 2;
    localparam int CW  = 3 * 8;
    localparam int T   = 5;
    localparam int W   = IDW + 1 + CW;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      req_valid;
    logic [N*24-1:0]   req_scale;
    logic [N*CW-1:0]   req_data;
    logic [N-1:0]      req_ready;
    logic              rsp_valid;
    logic [IDW-1:0]    rsp_id;
    logic [CW-1:0]     rsp_data;
    logic              rsp_error;
    logic [23:0]       ct_scale;
    logic              ct_in_enable;
    logic [CW-1:0]     ct_in_data;
    logic              ct_out_ready;
    logic [CW-1:0]     ct_out_data;
    logic              busy;

    logic [23:0]       scale_a [N];
    logic [CW-1:0]     data_a  [N];

    int                checks   = 0;
    int                failures = 0;
    int                last_m;
    logic [W-1:0]      exp_q[$];

    always #5 clk = ~clk;

    genvar g;
    for (g = 0; g < N; g++) begin : g_pack
        assign req_scale[g*24 +: 24] = scale_a[g];
        assign req_data[g*CW +: CW]  = data_a[g];
    end

    contrast_transform_arbiter #(
        .requesters(N), .id_width(IDW), .color_channels(3), .color_width(8), .timeout(T)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_scale(req_scale), .req_data(req_data), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_error(rsp_error),
        .ct_scale(ct_scale), .ct_in_enable(ct_in_enable), .ct_in_data(ct_in_data),
        .ct_out_ready(ct_out_ready), .ct_out_data(ct_out_data), .busy(busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Search order last+1, last+2, ... modulo N; -1 when nobody is requesting.
    function automatic int exp_winner(input int last, input logic [N-1:0] v);
        logic [N-1:0] sh;
        for (int k = 1; k <= N; k++) begin
            sh = v >> ((last + k) % N);
            if (sh[0]) return (last + k) % N;
        end
        return -1;
    endfunction

    task automatic rand_inputs();
        for (int i = 0; i < N; i++) begin
            scale_a[i] = 24'($urandom);
            data_a[i]  = CW'($urandom);
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            chk("idle_busy", busy, 1'b0);
            chk("idle_rsp_valid", rsp_valid, 1'b0);
            chk("idle_enable", ct_in_enable, 1'b0);
            chk("idle_ready", req_ready, '0);
            @(posedge clk); #1;
        end
    endtask

    // One job: accept, lat WAIT cycles before ct_out_ready, then RELEASE.
    task automatic serve(input int lat, input bit stale);
        int           w;
        int           done;
        logic [23:0]  e_scale;
        logic [CW-1:0] e_data;
        logic [CW-1:0] e_out;
        logic         e_err;
        logic [W-1:0] e_item;
        @(negedge clk);
        w = exp_winner(last_m, req_valid);
        chk("accept_busy", busy, 1'b0);
        chk("accept_rsp_valid", rsp_valid, 1'b0);
        chk("accept_enable", ct_in_enable, 1'b0);
        if (w < 0) begin
            chk("ready_none", req_ready, '0);
            @(posedge clk); #1;
            return;
        end
        chk("req_ready_grant", req_ready, N'(1) << w);
        e_scale = scale_a[w];
        e_data  = data_a[w];
        last_m  = w;
        e_err   = (lat > T);
        done    = e_err ? T + 1 : lat + 1;
        e_out   = '0;
        @(posedge clk); #1;
        for (int c = 1; c <= done + 1; c++) begin
            if (c == 1) rand_inputs();
            ct_out_data  = CW'($urandom);
            ct_out_ready = stale || (c - 1 == lat);
            if (c == done) begin
                if (!e_err) e_out = ct_out_data;
                exp_q.push_back({IDW'(w), e_err, e_out});
            end
            @(negedge clk);
            if (c <= done) begin
                chk("wait_enable", ct_in_enable, 1'b1);
                chk("wait_busy", busy, 1'b1);
                chk("wait_rsp_valid", rsp_valid, 1'b0);
                chk("wait_ready", req_ready, '0);
                chk("wait_scale", ct_scale, e_scale);
                chk("wait_data", ct_in_data, e_data);
            end else begin
                chk("rel_rsp_valid", rsp_valid, 1'b1);
                chk("rel_enable", ct_in_enable, 1'b0);
                chk("rel_busy", busy, 1'b1);
                chk("rel_scale", ct_scale, e_scale);
                chk("rel_queue", exp_q.size(), 1);
                if (exp_q.size() > 0) begin
                    e_item = exp_q.pop_front();
                    chk("rsp_id", rsp_id, e_item[W-1 -: IDW]);
                    chk("rsp_error", rsp_error, e_item[CW]);
                    chk("rsp_data", rsp_data, e_item[CW-1:0]);
                end
            end
            @(posedge clk); #1;
        end
        ct_out_ready = stale;
    endtask

    initial begin : main
        int w;
        rst          = 1'b1;
        req_valid    = '0;
        ct_out_ready = 1'b0;
        ct_out_data  = '0;
        last_m       = N - 1;
        rand_inputs();
        repeat (2) @(posedge clk);
        #1;
        req_valid = '1;
        @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_enable", ct_in_enable, 1'b0);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_scale", ct_scale, 24'h0);
        chk("rst_in_data", ct_in_data, '0);
        chk("rst_rsp_id", rsp_id, '0);
        chk("rst_rsp_data", rsp_data, '0);
        chk("rst_rsp_error", rsp_error, 1'b0);
        chk("rst_ready", req_ready, '0);

        // All four requesting from reset: 0,1,2,3,0,...
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (8) serve($urandom_range(0, 3), 1'b0);
        req_valid = '0;
        idle_cycles(2);

        // Single request from requester 1, datapath latency 4.
        scale_a[1] = 24'h001000;
        data_a[1]  = 24'h204060;
        req_valid  = 4'b0010;
        serve(4, 1'b0);
        req_valid = '0;
        idle_cycles(3);

        // Fairness between requesters 0 and 2.
        req_valid = 4'b0101;
        repeat (6) serve($urandom_range(0, 3), 1'b0);
        req_valid = '0;
        idle_cycles(1);

        // Watchdog: full timeout, result on the last allowed cycle, one cycle late, then normal.
        req_valid = 4'b1000;
        serve(20, 1'b0);
        serve(T, 1'b0);
        serve(T + 1, 1'b0);
        serve(2, 1'b0);
        req_valid = '0;
        idle_cycles(1);

        // Reset pulsed in the second WAIT cycle.
        req_valid = '1;
        @(negedge clk);
        w = exp_winner(last_m, req_valid);
        chk("rw_grant", req_ready, N'(1) << w);
        @(posedge clk); #1;
        @(negedge clk);
        chk("rw_wait1_enable", ct_in_enable, 1'b1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("rw_ready_in_rst", req_ready, '0);
        chk("rw_no_rsp", rsp_valid, 1'b0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("rw_busy", busy, 1'b0);
        chk("rw_enable", ct_in_enable, 1'b0);
        chk("rw_rsp_valid", rsp_valid, 1'b0);
        chk("rw_scale", ct_scale, 24'h0);
        chk("rw_in_data", ct_in_data, '0);
        chk("rw_rsp_id", rsp_id, '0);
        chk("rw_rsp_data", rsp_data, '0);
        chk("rw_rsp_error", rsp_error, 1'b0);
        chk("rw_ready", req_ready, '0);
        @(posedge clk); #1;
        rst    = 1'b0;
        last_m = N - 1;
        serve(1, 1'b0);
        req_valid = '0;
        idle_cycles(1);

        // Stale ct_out_ready held high: 3-cycle jobs, nothing spurious while idle.
        ct_out_ready = 1'b1;
        idle_cycles(2);
        req_valid = '1;
        repeat (6) serve(0, 1'b1);
        req_valid = '0;
        idle_cycles(2);
        ct_out_ready = 1'b0;

        // Random request patterns and latencies across the timeout boundary.
        repeat (25) begin
            req_valid = N'($urandom_range(1, 15));
            serve($urandom_range(0, 7), 1'b0);
        end
        req_valid = '0;
        idle_cycles(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
